spi_master: RTL and testbench

Mode-0 SPI master that drives the SCLK, MOSI and CS pins of an SPI slave from the system clock, and captures the slave's MISO. It sits directly upstream of the slave in the design. A parallel word is loaded with a single-cycle START and shifted out MSB-first. The word received from the slave is returned on RX_DATA, together with a one-cycle DONE pulse. It is the stimulus/driver stage used to exercise the slave from system logic.

---
 rtl/spi_master.sv | 121 ++++++++++++
 tb/tb_spi_master.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Mode-0 (CPOL=0, CPHA=0) SPI master, MSB-first, one DATA_W-bit word per START pulse.
// Build option: define SPI_MASTER_LOOPBACK_EN to receive from the internal MOSI instead of the MISO pin.
module spi_master #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [DATA_W-1:0] TX_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              SCLK,
  output logic              MOSI,
  output logic              CS,
  input  logic              MISO
);
  localparam int HW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_W + 1);

  generate
    if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
      $error("spi_master: DATA_W must be in 1..32");
    end
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("spi_master: CLK_DIV must be at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t            state_reg;
  logic [HW-1:0]     half_cnt_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic [DATA_W-1:0] tx_sh_reg;
  logic [DATA_W-1:0] rx_sh_reg;

  logic              rx_bit;
  logic              half_last;
  logic [DATA_W-1:0] tx_shifted;
  logic [DATA_W-1:0] rx_shifted;

`ifdef SPI_MASTER_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = MISO;
  assign rx_bit      = MOSI;
`else
  assign rx_bit      = MISO;
`endif

  assign half_last  = (half_cnt_reg == HW'(CLK_DIV - 1));
  assign tx_shifted = tx_sh_reg << 1;
  assign rx_shifted = (rx_sh_reg << 1) | DATA_W'(rx_bit);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= IDLE;
      half_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      tx_sh_reg    <= '0;
      rx_sh_reg    <= '0;
      BUSY         <= 1'b0;
      DONE         <= 1'b0;
      RX_DATA      <= '0;
      SCLK         <= 1'b0;
      MOSI         <= 1'b0;
      CS           <= 1'b1;
    end else begin
      DONE <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            state_reg    <= SETUP;
            tx_sh_reg    <= TX_DATA;
            rx_sh_reg    <= '0;
            half_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            CS           <= 1'b0;
            BUSY         <= 1'b1;
            MOSI         <= TX_DATA[DATA_W-1];
          end
        end
        // Both the initial setup phase and every low phase end in a rising SCLK,
        // unless the last bit has already been clocked, in which case the frame closes.
        SETUP, LOW: begin
          if (!half_last) begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end else begin
            half_cnt_reg <= '0;
            if (state_reg == LOW && bit_cnt_reg == BW'(DATA_W)) begin
              state_reg <= IDLE;
              CS        <= 1'b1;
              BUSY      <= 1'b0;
              DONE      <= 1'b1;
              MOSI      <= 1'b0;
              RX_DATA   <= rx_sh_reg;
            end else begin
              state_reg   <= HIGH;
              SCLK        <= 1'b1;
              rx_sh_reg   <= rx_shifted;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end
        end
        HIGH: begin
          if (!half_last) begin
            half_cnt_reg <= half_cnt_reg + 1'b1;
          end else begin
            half_cnt_reg <= '0;
            state_reg    <= LOW;
            SCLK         <= 1'b0;
            tx_sh_reg    <= tx_shifted;
            MOSI         <= tx_shifted[DATA_W-1];
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: cycle-accurate timeline model, SPI slave model, directed and random frames.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int W       = 8;
  localparam int D       = 10;
  localparam int END_REL = D * (2 * W + 1);
  localparam int W2      = 16;
  localparam int D2      = 2;
`ifdef SPI_MASTER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [W-1:0]  tx_data = '0;
  logic          miso = 1'b0;
  logic          busy, done, sclk, mosi, cs;
  logic [W-1:0]  rx_data;

  logic          start2 = 1'b0;
  logic [W2-1:0] tx_data2 = '0;
  logic          miso2 = 1'b0;
  logic          busy2, done2, sclk2, mosi2, cs2;
  logic [W2-1:0] rx_data2;

  always #5 clk = ~clk;

  spi_master #(.DATA_W(W), .CLK_DIV(D)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .TX_DATA(tx_data),
    .BUSY(busy), .DONE(done), .RX_DATA(rx_data),
    .SCLK(sclk), .MOSI(mosi), .CS(cs), .MISO(miso)
  );

  spi_master #(.DATA_W(W2), .CLK_DIV(D2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .START(start2), .TX_DATA(tx_data2),
    .BUSY(busy2), .DONE(done2), .RX_DATA(rx_data2),
    .SCLK(sclk2), .MOSI(mosi2), .CS(cs2), .MISO(miso2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slave models: present a word MSB-first from CS fall, advance on each SCLK fall, record MOSI on SCLK rise.
  logic [W-1:0]  slave_word = '0, s_sh = '0, mosi_cap = '0;
  logic [W2-1:0] slave_word2 = '0, s_sh2 = '0, mosi_cap2 = '0;

  always @(negedge cs) begin
    s_sh <= slave_word; miso <= LB ? 1'b0 : slave_word[W-1]; mosi_cap <= '0;
  end
  always @(negedge sclk) begin
    s_sh <= s_sh << 1; miso <= LB ? 1'b0 : s_sh[W-2];
  end
  always @(posedge sclk) mosi_cap <= {mosi_cap[W-2:0], mosi};

  always @(negedge cs2) begin
    s_sh2 <= slave_word2; miso2 <= LB ? 1'b0 : slave_word2[W2-1]; mosi_cap2 <= '0;
  end
  always @(negedge sclk2) begin
    s_sh2 <= s_sh2 << 1; miso2 <= LB ? 1'b0 : s_sh2[W2-2];
  end
  always @(posedge sclk2) mosi_cap2 <= {mosi_cap2[W2-2:0], mosi2};

  // Timeline model: a frame is "edges since acceptance"; every pin follows from that number.
  bit           m_active = 1'b0;
  bit           m_done = 1'b0;
  int           m_rel = 0;
  logic [W-1:0] m_tx = '0, m_exp_rx = '0, m_rx_hold = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0; m_done <= 1'b0; m_rel <= 0; m_rx_hold <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_active) begin
        if (m_rel + 1 == END_REL) begin
          m_active <= 1'b0; m_done <= 1'b1; m_rx_hold <= m_exp_rx;
        end
        m_rel <= m_rel + 1;
      end else if (start) begin
        m_active <= 1'b1; m_rel <= 0; m_tx <= tx_data;
        m_exp_rx <= LB ? tx_data : slave_word;
      end
    end
  end

  always @(posedge clk) begin
    int idx;
    #1;
    check("cs", cs, !m_active);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("sclk", sclk, m_active && ((m_rel / D) % 2 == 1));
    check("rx_data", rx_data, m_rx_hold);
    if (!m_active) begin
      check("mosi_idle", mosi, 1'b0);
    end else if (m_rel < 2 * W * D) begin
      idx = W - 1 - m_rel / (2 * D);
      check("mosi_bit", mosi, m_tx[idx]);
    end
  end

  task automatic start_xfer(input logic [W-1:0] tx, input logic [W-1:0] sw, output int t0);
    @(negedge clk); tx_data = tx; slave_word = sw; start = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input bit spam, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (spam) begin
        start = 1'($urandom_range(0, 1)); tx_data = W'($urandom);
      end
      @(posedge clk); #1;
      if (done) begin edge_no = cyc; break; end
    end
    start = 1'b0;
    if (edge_no < 0) check("done_timeout", done, 1'b1);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, e;
    logic [W-1:0] tx_r, sw_r;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("reset_cs", cs, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_rx", rx_data, 8'h00);
    repeat (2) @(negedge clk);

    // Basic frame: 0xA5 out, slave returns 0x3C.
    start_xfer(8'hA5, 8'h3C, t0);
    wait_done(END_REL + 20, 1'b0, e);
    check("t1_done_edge", e - t0, 170);
    check("t1_rx", rx_data, LB ? 8'hA5 : 8'h3C);
    check("t1_mosi_bits", mosi_cap, 8'hA5);
    check("t1_cs_at_done", cs, 1'b1);
    check("t1_busy_at_done", busy, 1'b0);
    $display("xfer tx=a5 rx=%h done_edge=%0d", rx_data, e - t0);
    repeat (5) @(negedge clk);

    // START held for 50 cycles: one frame only.
    @(negedge clk); tx_data = 8'h96; slave_word = 8'h69; start = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    repeat (49) @(negedge clk);
    start = 1'b0;
    wait_done(END_REL, 1'b0, e);
    check("t2_done_edge", e - t0, 170);
    check("t2_rx", rx_data, LB ? 8'h96 : 8'h69);
    repeat (20) @(posedge clk);
    #1 check("t2_no_second", busy, 1'b0);
    $display("xfer tx=96 rx=%h done_edge=%0d", rx_data, e - t0);

    // Back-to-back frames, second START in the DONE cycle.
    start_xfer(8'h0F, 8'h81, t0);
    wait_done(END_REL + 20, 1'b0, e);
    check("t3a_rx", rx_data, LB ? 8'h0F : 8'h81);
    $display("xfer tx=0f rx=%h done_edge=%0d", rx_data, e - t0);
    start_xfer(8'hF0, 8'h7E, t1);
    check("t3_gap", t1 - e, 1);
    check("t3_cs_low", cs, 1'b0);
    wait_done(END_REL + 20, 1'b0, e);
    check("t3b_done_edge", e - t0, 341);
    check("t3b_rx", rx_data, LB ? 8'hF0 : 8'h7E);
    $display("xfer tx=f0 rx=%h done_edge=%0d", rx_data, e - t0);

    // Asynchronous reset mid-frame.
    start_xfer(8'h6B, 8'h99, t0);
    while (cyc < t0 + 90) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("rst_sclk", sclk, 1'b0);
    check("rst_cs", cs, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rx", rx_data, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    start_xfer(8'h5A, 8'hC3, t0);
    wait_done(END_REL + 20, 1'b0, e);
    check("t4_done_edge", e - t0, 170);
    check("t4_rx", rx_data, LB ? 8'h5A : 8'hC3);
    $display("xfer tx=5a rx=%h done_edge=%0d (after reset)", rx_data, e - t0);

    // Randomized frames with START/TX_DATA noise while busy.
    for (int n = 0; n < 25; n++) begin
      tx_r = W'($urandom);
      sw_r = W'($urandom);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      start_xfer(tx_r, sw_r, t0);
      wait_done(END_REL + 20, 1'b1, e);
      check("rand_done_edge", e - t0, END_REL);
      check("rand_rx", rx_data, LB ? tx_r : sw_r);
      check("rand_mosi_bits", mosi_cap, tx_r);
      $display("xfer %0d tx=%h slave=%h rx=%h done_edge=%0d", n, tx_r, sw_r, rx_data, e - t0);
    end

    // 16-bit instance with the fastest divider.
    @(negedge clk); tx_data2 = 16'hBEEF; slave_word2 = 16'h1234; start2 = 1'b1;
    @(posedge clk); #1; t0 = cyc;
    @(negedge clk); start2 = 1'b0;
    e = -1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done2) begin e = cyc; break; end
    end
    if (e < 0) check("dut2_timeout", done2, 1'b1);
    check("dut2_done_edge", e - t0, 66);
    check("dut2_rx", rx_data2, LB ? 16'hBEEF : 16'h1234);
    check("dut2_mosi_bits", mosi_cap2, 16'hBEEF);
    check("dut2_cs_at_done", cs2, 1'b1);
    check("dut2_busy_at_done", busy2, 1'b0);
    $display("xfer16 tx=beef rx=%h done_edge=%0d", rx_data2, e - t0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
